// File: rtl/demux_8bit_latch.sv
// Serial-to-parallel demultiplexer: routes D into Q by auto-incrementing pointer or address S.
// Optional `DEMUX_PARITY_EN adds a registered even-parity output of each completed frame.
module demux_8bit_latch (
   input  logic       clk,
   input  logic       rst,
   input  logic       D,
   input  logic [2:0] S,
   input  logic       auto,
   input  logic       in_valid,
   input  logic       clear,
   output logic       in_ready,
   output logic [7:0] Q,
   output logic       frame_done,
   output logic       busy,
`ifdef DEMUX_PARITY_EN
   output logic [3:0] wr_cnt,
   output logic       parity
`else
   output logic [3:0] wr_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t     state, state_nxt;
   logic       mode, mode_eff, take, fresh;
   logic [2:0] ptr, idx;
   logic [7:0] mask, mask_nxt, onehot, q_nxt;

   // The first transfer of a frame uses the live auto input; later ones use the latched mode.
   always_comb begin
      take     = in_valid && (state != DONE);
      mode_eff = (state == IDLE) ? auto : mode;
      idx      = mode_eff ? ptr : S;
      onehot   = 8'b1 << idx;
      fresh    = (mask & onehot) == '0;
      mask_nxt = mask | onehot;
      q_nxt    = D ? (Q | onehot) : (Q & ~onehot);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = FILL;
         FILL:    if (take && mask_nxt == '1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         Q      <= '0;
         mask   <= '0;
         ptr    <= '0;
         wr_cnt <= '0;
         mode   <= 1'b0;
      end else if (clear) begin
         state  <= IDLE;
         Q      <= '0;
         mask   <= '0;
         ptr    <= '0;
         wr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            Q    <= q_nxt;
            mask <= mask_nxt;
            ptr  <= ptr + 3'd1;
            if (fresh) wr_cnt <= wr_cnt + 4'd1;
            if (state == IDLE) mode <= auto;
         end else if (state == DONE) begin
            mask   <= '0;
            ptr    <= '0;
            wr_cnt <= '0;
         end
      end
   end

`ifdef DEMUX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity <= 1'b0;
      else if (clear)
         parity <= 1'b0;
      else if (take && state == FILL && mask_nxt == '1)
         parity <= ^q_nxt;
   end
`endif

   assign in_ready   = (state != DONE);
   assign busy       = (state == FILL);
   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_demux_8bit_latch.sv
// Self-checking bench: directed frames with literal expectations plus randomized traffic
// compared every cycle against a set/count based reference model.
module tb_demux_8bit_latch;

   logic       clk = 1'b0;
   logic       rst, D, auto, in_valid, clear;
   logic [2:0] S;
   logic       in_ready, frame_done, busy;
   logic [7:0] Q;
   logic [3:0] wr_cnt;
`ifdef DEMUX_PARITY_EN
   logic       parity;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;
   bit          cmp_en = 1'b0;

   demux_8bit_latch dut (
      .clk(clk), .rst(rst), .D(D), .S(S), .auto(auto), .in_valid(in_valid), .clear(clear),
      .in_ready(in_ready), .Q(Q), .frame_done(frame_done), .busy(busy),
`ifdef DEMUX_PARITY_EN
      .wr_cnt(wr_cnt), .parity(parity)
`else
      .wr_cnt(wr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: a set of written positions, a frame flag and a completion flag.
   bit [7:0] m_q = '0;
   bit       m_written [8];
   int       m_cnt = 0, m_pos = 0;
   bit       m_auto = 1'b0, m_in_frame = 1'b0, m_done = 1'b0, m_par = 1'b0;

   task automatic m_wipe();
      foreach (m_written[i]) m_written[i] = 1'b0;
      m_cnt = 0;
      m_pos = 0;
      m_in_frame = 1'b0;
      m_done = 1'b0;
   endtask

   always @(posedge clk or posedge rst) begin
      int idx;
      if (rst || clear) begin
         m_wipe();
         m_q = '0;
         m_par = 1'b0;
         if (rst) m_auto = 1'b0;
      end else if (m_done) begin
         m_wipe();
      end else if (in_valid) begin
         if (!m_in_frame) begin
            m_in_frame = 1'b1;
            m_auto = auto;
            m_pos = 0;
         end
         idx = m_auto ? m_pos : int'(S);
         m_q[idx] = D;
         if (!m_written[idx]) begin
            m_written[idx] = 1'b1;
            m_cnt++;
         end
         m_pos = (m_pos + 1) % 8;
         if (m_cnt == 8) begin
            m_done = 1'b1;
            m_par = ^m_q;
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m.Q", Q, m_q);
         chk("m.in_ready", {7'b0, in_ready}, {7'b0, !m_done});
         chk("m.busy", {7'b0, busy}, {7'b0, m_in_frame && !m_done});
         chk("m.frame_done", {7'b0, frame_done}, {7'b0, m_done});
         chk("m.wr_cnt", {4'b0, wr_cnt}, 8'(m_cnt));
`ifdef DEMUX_PARITY_EN
         chk("m.parity", {7'b0, parity}, {7'b0, m_par});
`endif
      end
   end

   // Called at a negedge: drive one cycle of inputs and return at the next negedge.
   task automatic cyc(input bit v, input bit d, input bit [2:0] s, input bit a, input bit c);
      in_valid = v; D = d; S = s; auto = a; clear = c;
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst.Q", Q, 8'h00);
      chk("rst.wr_cnt", {4'b0, wr_cnt}, 8'h00);
      chk("rst.flags", {5'b0, in_ready, busy, frame_done}, 8'b100);
      @(negedge clk);
      rst = 1'b0;
   endtask

   bit [7:0] pat;

   initial begin
      rst = 1'b1; D = 0; S = '0; auto = 0; in_valid = 0; clear = 0;
      repeat (2) @(negedge clk);
      chk("reset.Q", Q, 8'h00);
      chk("reset.flags", {5'b0, in_ready, busy, frame_done}, 8'b100);
      chk("reset.wr_cnt", {4'b0, wr_cnt}, 8'h00);
      rst = 1'b0;
      cmp_en = 1'b1;

      // Auto frame: D = 1,0,1,1,0,0,1,0 -> 8'h4D
      pat = 8'b0100_1101;
      for (int i = 0; i < 8; i++) cyc(1, pat[i], 3'd5, 1, 0);
      chk("auto.Q", Q, 8'h4D);
      chk("auto.done", {6'b0, frame_done, in_ready}, 8'b10);
`ifdef DEMUX_PARITY_EN
      chk("auto.parity", {7'b0, parity}, 8'h00);
`endif
      cyc(0, 0, 0, 0, 0);
      chk("auto.after", {frame_done, 3'b0, wr_cnt}, 8'h00);

      // Addressed frame: S = 7..0, D = 1 except S = 3 -> 8'hF7
      for (int i = 7; i >= 0; i--) begin
         cyc(1, (i != 3), 3'(i), 0, 0);
         if (i > 0) chk("addr.no_done", {7'b0, frame_done}, 8'h00);
      end
      chk("addr.Q", Q, 8'hF7);
      chk("addr.done", {7'b0, frame_done}, 8'h01);
`ifdef DEMUX_PARITY_EN
      chk("addr.parity", {7'b0, parity}, 8'h01);
`endif
      cyc(0, 0, 0, 0, 0);

      // Duplicate index: S = 2 three times, then the other seven
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 3'd2, 0, 0);
         chk("dup.wr_cnt", {4'b0, wr_cnt}, 8'h01);
      end
      for (int i = 0; i < 8; i++) begin
         if (i == 2) continue;
         cyc(1, 0, 3'(i), 1, 0);
         chk("dup.done", {7'b0, frame_done}, {7'b0, i == 7});
      end
      chk("dup.Q", Q, 8'h04);
      cyc(0, 0, 0, 0, 0);

      // Clear with same-cycle transfer after 5 auto transfers
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 0);
      cyc(1, 1, 0, 1, 1);
      chk("clr.Q", Q, 8'h00);
      chk("clr.state", {wr_cnt, 1'b0, in_ready, busy, frame_done}, 8'b0000_0100);
      cyc(0, 0, 0, 0, 0);

      // Asynchronous reset mid-frame, then first transfer accepted at once
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, 1, 0);
      in_valid = 0;
      async_reset();
      cyc(1, 1, 3'd6, 0, 0);
      chk("post_rst.Q", Q, 8'h40);
      chk("post_rst.busy", {7'b0, busy}, 8'h01);
      cyc(1, 0, 3'd6, 0, 1);

      // Mode latch and DONE back-pressure: auto dropped at transfer 4, valid held in DONE
      for (int i = 0; i < 8; i++) cyc(1, (i % 2 == 0), 3'd0, (i < 3), 0);
      chk("latch.Q", Q, 8'h55);
      chk("latch.done", {7'b0, frame_done}, 8'h01);
      cyc(1, 0, 3'd0, 0, 0);
      chk("latch.ignored", Q, 8'h55);
      chk("latch.idle", {5'b0, in_ready, busy, frame_done}, 8'b100);
      cyc(0, 0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            in_valid = 0;
            async_reset();
         end else begin
            cyc(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 59) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
